good_counter: RTL and testbench



---
 rtl/good_counter_pkg.sv | 18 +
 rtl/good_counter.sv | 43 ++++
 tb/tb_good_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/good_counter_pkg.sv
// Shared constants, count type and parameter-legality helper for good_counter.
package good_counter_pkg;

    localparam int DEFAULT_WIDTH = 2;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    // A terminal count of zero would make the counter a constant, so it is rejected.
    function automatic bit max_count_legal(input int width, input longint unsigned max_count);
        longint unsigned full_scale;
        if (width < 1 || width > 32) begin
            return 1'b0;
        end
        full_scale = (64'd1 << width) - 64'd1;
        return (max_count >= 64'd1) && (max_count <= full_scale);
    endfunction

endpackage

// File: rtl/good_counter.sv
// Free-running modulo up-counter with terminal-count flag and registered wrap pulse.
module good_counter
    import good_counter_pkg::*;
#(
    parameter int              WIDTH     = DEFAULT_WIDTH,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    if (!max_count_legal(WIDTH, MAX_COUNT)) begin : g_bad_params
        $error("good_counter: illegal WIDTH=%0d / MAX_COUNT=%0d", WIDTH, MAX_COUNT);
    end

    // Initialisers give a defined power-up value even if reset is never asserted.
    logic [WIDTH-1:0] cnt_q  = '0;
    logic             wrap_q = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (cnt_q == MAX_VAL) begin
            cnt_q  <= '0;
            wrap_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + ONE;
            wrap_q <= 1'b0;
        end
    end

    assign cnt    = cnt_q;
    assign wrap   = wrap_q;
    assign at_max = (cnt_q == MAX_VAL);

endmodule

// File: tb/tb_good_counter.sv
// Scoreboard bench for good_counter: default 2-bit instance and a WIDTH=3/MAX_COUNT=5 instance.
module tb_good_counter;
    import good_counter_pkg::*;

    localparam int MAX_A = 3;
    localparam int MAX_B = 5;

    typedef struct {
        int cnt_a;
        bit wrap_a;
        int cnt_b;
        bit wrap_b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       reset_b;
    logic [1:0] cnt_a;
    logic       at_max_a;
    logic       wrap_a;
    logic [2:0] cnt_b;
    logic       at_max_b;
    logic       wrap_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt_a = 0;
    bit   m_wrap_a = 1'b0;
    int   m_cnt_b = 0;
    bit   m_wrap_b = 1'b0;
    int   wraps_b;
    exp_t sb[$];

    good_counter u_dut_a (
        .clk    (clk),
        .reset  (reset_a),
        .cnt    (cnt_a),
        .at_max (at_max_a),
        .wrap   (wrap_a)
    );

    good_counter #(.WIDTH(3), .MAX_COUNT(5)) u_dut_b (
        .clk    (clk),
        .reset  (reset_b),
        .cnt    (cnt_b),
        .at_max (at_max_b),
        .wrap   (wrap_b)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of reset values, predict the post-edge state, then compare after the edge.
    task automatic step(input logic ra, input logic rb);
        exp_t e;
        exp_t got;
        reset_a = ra;
        reset_b = rb;
        if (!ra) begin
            m_cnt_a = 0; m_wrap_a = 1'b0;
        end else if (m_cnt_a == MAX_A) begin
            m_cnt_a = 0; m_wrap_a = 1'b1;
        end else begin
            m_cnt_a = m_cnt_a + 1; m_wrap_a = 1'b0;
        end
        if (!rb) begin
            m_cnt_b = 0; m_wrap_b = 1'b0;
        end else if (m_cnt_b == MAX_B) begin
            m_cnt_b = 0; m_wrap_b = 1'b1;
        end else begin
            m_cnt_b = m_cnt_b + 1; m_wrap_b = 1'b0;
        end
        e.cnt_a = m_cnt_a; e.wrap_a = m_wrap_a;
        e.cnt_b = m_cnt_b; e.wrap_b = m_wrap_b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check_val("cnt_a", 32'(cnt_a), 32'(got.cnt_a));
            check_val("wrap_a", 32'(wrap_a), 32'(got.wrap_a));
            check_val("at_max_a", 32'(at_max_a), 32'(got.cnt_a == MAX_A));
            check_val("cnt_b", 32'(cnt_b), 32'(got.cnt_b));
            check_val("wrap_b", 32'(wrap_b), 32'(got.wrap_b));
            check_val("at_max_b", 32'(at_max_b), 32'(got.cnt_b == MAX_B));
            check_val("b_range", 32'(cnt_b <= 3'd5), 32'd1);
        end
    endtask

    initial begin
        int seq_a[5];
        int seq_b[12];
        int guard;
        longint t0;
        longint edge_t;
        logic r;
        seq_a = '{1, 2, 3, 0, 1};
        seq_b = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};

        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        check_val("pwrup_cnt_a", 32'(cnt_a), 32'd0);
        check_val("pwrup_wrap_a", 32'(wrap_a), 32'd0);
        check_val("pwrup_cnt_b", 32'(cnt_b), 32'd0);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check_val("rst_hold_cnt", 32'(cnt_a), 32'd0);
        check_val("rst_hold_wrap", 32'(wrap_a), 32'd0);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check_val("release_seq", 32'(cnt_a), 32'(seq_a[i]));
            check_val("release_at_max", 32'(at_max_a), 32'(seq_a[i] == 3));
        end

        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

        guard = 0;
        while (m_cnt_a != 2 && guard < 8) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_val("mid_reach2", 32'(cnt_a), 32'd2);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check_val("mid_hold", 32'(cnt_a), 32'd0);
        end
        step(1'b1, 1'b1);
        check_val("mid_release", 32'(cnt_a), 32'd1);

        guard = 0;
        while (m_cnt_a != 3 && guard < 8) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_val("term_reach3", 32'(cnt_a), 32'd3);
        step(1'b0, 1'b1);
        check_val("term_rst_cnt", 32'(cnt_a), 32'd0);
        check_val("term_rst_wrap", 32'(wrap_a), 32'd0);

        step(1'b1, 1'b0);
        check_val("b_rst", 32'(cnt_b), 32'd0);
        wraps_b = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1);
            check_val("b_seq", 32'(cnt_b), 32'(seq_b[i]));
            if (wrap_b === 1'b1) wraps_b++;
        end
        check_val("b_wrap_count", 32'(wraps_b), 32'd2);

        // Reset level at each edge follows a 1547 ns toggle schedule starting in run.
        t0 = $time;
        for (int i = 0; i < 150; i++) begin
            edge_t = longint'($time) + 19 - t0;
            r = ((edge_t / 1547) % 2 == 0) ? 1'b1 : 1'b0;
            step(r, r);
            check_val("long_no_x", 32'(^{cnt_a, wrap_a, at_max_a, cnt_b, wrap_b, at_max_b} !== 1'bx), 32'd1);
        end

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
